// File: rtl/cntarr_pkg.sv
// Shared constants for the counter array: register offsets, CTRL bit positions,
// address field positions and the byte-lane merge helper.
package cntarr_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_RELOAD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_IE      = 3;

    localparam int ADR_REG_LSB = 2;
    localparam int ADR_REG_MSB = 3;
    localparam int ADR_CH_LSB  = 4;
    localparam int ADR_CH_MSB  = 6;

    localparam int FREEZE_BIT = 96;

    // Replace only the bytes whose select lane is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] data,
                                               input logic [3:0]  sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_val & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/cntarr_channel.sv
// One counter channel: CTRL/COUNT/RELOAD/TF state plus step and terminal logic.
// The IE bit is only writable when CNTARR_IRQ_EN is defined.
module cntarr_channel
    import cntarr_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [1:0]      wr_reg,
    input  logic [31:0]     wr_data,
    input  logic [3:0]      wr_sel,
    input  logic            freeze,
    output logic [3:0]      ctrl,
    output logic [BITS-1:0] count,
    output logic [BITS-1:0] reload,
    output logic            tf
);

`ifdef CNTARR_IRQ_EN
    localparam logic [3:0] CTRL_WMASK = 4'b1111;
`else
    localparam logic [3:0] CTRL_WMASK = 4'b0111;
`endif

    logic            wr_ctrl;
    logic            wr_count;
    logic            wr_reload;
    logic            wr_status;
    logic            step;
    logic            terminal;
    logic [BITS-1:0] count_next;

    assign wr_ctrl   = wr_en && (wr_reg == REG_CTRL);
    assign wr_count  = wr_en && (wr_reg == REG_COUNT);
    assign wr_reload = wr_en && (wr_reg == REG_RELOAD);
    assign wr_status = wr_en && (wr_reg == REG_STATUS);

    // A bus write to CTRL or COUNT pre-empts the step in that cycle.
    assign step     = ctrl[CTRL_EN] && !freeze && !wr_ctrl && !wr_count;
    assign terminal = ctrl[CTRL_DIR] ? (count == '0) : (count == reload);

    always_comb begin
        count_next = count;
        if (terminal) begin
            if (!ctrl[CTRL_ONESHOT]) begin
                count_next = ctrl[CTRL_DIR] ? reload : '0;
            end
        end else begin
            count_next = ctrl[CTRL_DIR] ? (count - BITS'(1)) : (count + BITS'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl   <= '0;
            count  <= '0;
            reload <= '0;
            tf     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= 4'(lane_merge({28'd0, ctrl}, wr_data, wr_sel)) & CTRL_WMASK;
            end else if (step && terminal && ctrl[CTRL_ONESHOT]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (wr_count) begin
                count <= BITS'(lane_merge(32'(count), wr_data, wr_sel));
            end else if (step) begin
                count <= count_next;
            end

            if (wr_reload) begin
                reload <= BITS'(lane_merge(32'(reload), wr_data, wr_sel));
            end

            // A new terminal event beats a simultaneous write-1-to-clear.
            if (step && terminal) begin
                tf <= 1'b1;
            end else if (wr_status && wr_sel[0] && wr_data[0]) begin
                tf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/counter_array.sv
// Multi-channel counter array on a Wishbone slave: decode, read mux, ack, LA/IO
// mapping and terminal IRQ (IRQ logic present only with CNTARR_IRQ_EN defined).
module counter_array
    import cntarr_pkg::*;
#(
    parameter int BITS         = 32,
    parameter int CHANNELS     = 4,
    parameter int MPRJ_IO_PADS = 38
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [127:0]            la_data_in,
    input  logic [127:0]            la_oenb,
    output logic [127:0]            la_data_out,
    output logic [MPRJ_IO_PADS-1:0] io_out,
    output logic [MPRJ_IO_PADS-1:0] io_oeb,
    output logic [2:0]              irq
);

    // Handshake: a request is valid while cyc & stb; the slave answers with a
    // single-cycle ack one clock later, and the access (write or read sample)
    // happens on that ack edge. A master holding valid gets one ack every
    // two cycles.
    logic                valid;
    logic                take;
    logic [2:0]          ch_idx;
    logic [1:0]          reg_idx;
    logic                freeze;
    logic [31:0]         rd_data;
    logic                oeb_q;

    logic [3:0]          ch_ctrl   [CHANNELS];
    logic [BITS-1:0]     ch_count  [CHANNELS];
    logic [BITS-1:0]     ch_reload [CHANNELS];
    logic [CHANNELS-1:0] ch_tf;

    logic unused_inputs;

    assign valid   = wbs_cyc_i && wbs_stb_i;
    assign take    = valid && !wbs_ack_o;
    assign ch_idx  = wbs_adr_i[ADR_CH_MSB:ADR_CH_LSB];
    assign reg_idx = wbs_adr_i[ADR_REG_MSB:ADR_REG_LSB];
    assign freeze  = !la_oenb[FREEZE_BIT] && la_data_in[FREEZE_BIT];

    assign unused_inputs = ^{wbs_adr_i[31:7], wbs_adr_i[1:0],
                             la_data_in[127:97], la_data_in[95:0],
                             la_oenb[127:97], la_oenb[95:0]};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        cntarr_channel #(
            .BITS (BITS)
        ) u_channel (
            .clk     (wb_clk_i),
            .rst_n   (wb_rst_ni),
            .wr_en   (take && wbs_we_i && (ch_idx == 3'(g))),
            .wr_reg  (reg_idx),
            .wr_data (wbs_dat_i),
            .wr_sel  (wbs_sel_i),
            .freeze  (freeze),
            .ctrl    (ch_ctrl[g]),
            .count   (ch_count[g]),
            .reload  (ch_reload[g]),
            .tf      (ch_tf[g])
        );
    end

    // Channel indices with no counter fall through and read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_idx == 3'(i)) begin
                case (reg_idx)
                    REG_CTRL:   rd_data = {28'd0, ch_ctrl[i]};
                    REG_COUNT:  rd_data = 32'(ch_count[i]);
                    REG_RELOAD: rd_data = 32'(ch_reload[i]);
                    default:    rd_data = {31'd0, ch_tf[i]};
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            oeb_q     <= 1'b1;
        end else begin
            wbs_ack_o <= take;
            oeb_q     <= 1'b0;
            if (take && !wbs_we_i) begin
                wbs_dat_o <= rd_data;
            end
        end
    end

`ifdef CNTARR_IRQ_EN
    logic [CHANNELS-1:0] ch_ie;
    logic                irq_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ie
        assign ch_ie[g] = ch_ctrl[g][CTRL_IE];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(ch_tf & ch_ie);
        end
    end

    assign irq = {2'b00, irq_q};
`else
    assign irq = 3'b000;
`endif

    always_comb begin
        la_data_out                 = '0;
        la_data_out[CHANNELS-1:0]   = ch_tf;
        la_data_out[32 +: BITS]     = ch_count[0];
        io_out                      = '0;
        io_out[BITS-1:0]            = ch_count[0];
    end

    assign io_oeb = {MPRJ_IO_PADS{oeb_q}};

endmodule
